// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and parity mode.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    // 1'b0 selects even parity, 1'b1 odd parity
    localparam logic PARITY_ODD = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input.
// Both flops reset to the idle line level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 framing
// with an extra parity_err output.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic        rx_s;
    uart_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  data_n;
    logic        valid_n;
    logic        fe_n;
    logic        ov_n;
    logic        brk, brk_n;
    logic        good;
`ifdef UART_RX_PARITY_EN
    logic        par_bit, par_bit_n;
    logic        pe_n;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = data_out;
        valid_n   = valid && !ready;
        fe_n      = 1'b0;
        ov_n      = 1'b0;
        brk_n     = brk;
        good      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
        pe_n      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                // after a framing error, wait for the line to go high
                if (brk) begin
                    if (rx_s)
                        brk_n = 1'b0;
                end else if (!rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    par_bit_n = rx_s;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rx_s) begin
                        fe_n  = 1'b1;
                        brk_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if ((^shreg ^ par_bit) != PARITY_ODD) begin
                        pe_n = 1'b1;
`endif
                    end else begin
                        good = 1'b1;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        if (good) begin
            if (!valid || ready) begin
                data_n  = shreg;
                valid_n = 1'b1;
            end else begin
                ov_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            brk       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            data_out  <= data_n;
            valid     <= valid_n;
            frame_err <= fe_n;
            overrun   <= ov_n;
            brk       <= brk_n;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_n;
            parity_err <= pe_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed cases plus random frames
// scored against a transaction-level model of the byte/handshake rules.
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int BIT = CPB * 10;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    int fe_cnt = 0;
    int ov_cnt = 0;
    int cons_cnt = 0;
    int busy_cnt = 0;
    int valid_cycles = 0;
    logic [7:0] cons_last = 8'h00;
`ifdef UART_RX_PARITY_EN
    int pe_cnt = 0;
`endif

    always @(negedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (valid) valid_cycles <= valid_cycles + 1;
        if (valid && ready) begin
            cons_cnt  <= cons_cnt + 1;
            cons_last <= data_out;
        end
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
    end

    logic [7:0] md = 8'h00;
    bit         mv = 1'b0;
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         exp_cons = 0;
    logic [7:0] exp_last = 8'h00;
`ifdef UART_RX_PARITY_EN
    int         exp_pe = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " valid"}, 32'(valid), 32'(mv));
        check({tag, " data_out"}, 32'(data_out), 32'(md));
        check({tag, " frame_err"}, fe_cnt, exp_fe);
        check({tag, " overrun"}, ov_cnt, exp_ov);
        check({tag, " consumed"}, cons_cnt, exp_cons);
        check({tag, " last"}, 32'(cons_last), 32'(exp_last));
`ifdef UART_RX_PARITY_EN
        check({tag, " parity_err"}, pe_cnt, exp_pe);
`endif
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        ready = v;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_ok, input int gap);
        rx = 1'b0;
        #(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(BIT);
        end
        if (PAR_EN) begin
            rx = par_ok ? ^d : ~^d;
            #(BIT);
        end
        rx = stop;
        #(BIT);
        if (gap > 0) begin
            rx = 1'b1;
            #(BIT * gap);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input logic stop,
                        input logic par_ok, input int gap);
        if (ready && mv) begin
            exp_cons++;
            exp_last = md;
            mv = 1'b0;
        end
        send_frame(d, stop, par_ok, gap);
        if (!stop) begin
            exp_fe++;
        end else if (PAR_EN && !par_ok) begin
`ifdef UART_RX_PARITY_EN
            exp_pe++;
`endif
        end else if (mv && !ready) begin
            exp_ov++;
        end else begin
            md = d;
            if (ready) begin
                exp_cons++;
                exp_last = d;
            end else begin
                mv = 1'b1;
            end
        end
    endtask

    initial begin
        int b0;
        int v0;
        logic [7:0] ff;

        #23;
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset valid", 32'(valid), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset overrun", 32'(overrun), 0);
        check("reset busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #(BIT);

        set_ready(1'b1);
        v0 = valid_cycles;
        xfer(8'h81, 1'b1, 1'b1, 2);
        check_state("byte81");
        check("byte81 valid width", valid_cycles - v0, 1);

        b0 = busy_cnt;
        v0 = valid_cycles;
        rx = 1'b0;
        #40;
        rx = 1'b1;
        #(BIT * 2);
        check("glitch busy seen", 32'(busy_cnt > b0), 1);
        check("glitch busy now", 32'(busy), 0);
        check("glitch no valid", valid_cycles - v0, 0);
        check_state("glitch");

        xfer(8'hAA, 1'b0, 1'b1, 0);
        b0 = busy_cnt;
        #(BIT * 2);
        check("break busy", busy_cnt - b0, 0);
        rx = 1'b1;
        #(BIT);
        check_state("badstop");
        xfer(8'h8B, 1'b1, 1'b1, 2);
        check_state("after break");

        set_ready(1'b0);
        xfer(8'h8B, 1'b1, 1'b1, 0);
        xfer(8'hAA, 1'b1, 1'b1, 2);
        check_state("overrun");
        set_ready(1'b1);
        exp_cons++;
        exp_last = md;
        mv = 1'b0;
        #(BIT);
        check_state("drain");

        ff = 8'hFF;
        rx = 1'b0;
        #(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = ff[i];
            #(BIT);
        end
        rx = 1'b1;
        #(BIT / 2);
        check("mid busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst data_out", 32'(data_out), 32'h00);
        check("rst valid", 32'(valid), 0);
        check("rst frame_err", 32'(frame_err), 0);
        check("rst overrun", 32'(overrun), 0);
        check("rst busy", 32'(busy), 0);
        md = 8'h00;
        mv = 1'b0;
        #30;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #(BIT * 2);
        check_state("post reset");
        xfer(8'h01, 1'b1, 1'b1, 2);
        check_state("byte01");

`ifdef UART_RX_PARITY_EN
        set_ready(1'b0);
        xfer(8'h07, 1'b1, 1'b0, 2);
        check_state("parity bad");
        xfer(8'h07, 1'b1, 1'b1, 2);
        check_state("parity good");
`endif

        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic stop;
            logic pok;
            int gap;
            d = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            pok = ($urandom_range(0, 7) != 0);
            gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            set_ready(1'($urandom_range(0, 1)));
            xfer(d, stop, pok, gap);
            check_state($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clocks per serial bit period; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  serial line fed by the transmitter tx; idles high.
REQ-005 SHALL have port data_out  output  8  last received byte, LSB received first.
REQ-006 SHALL have port valid  output  1  data_out holds an unconsumed byte.
REQ-007 SHALL have port ready  input  1  consumer accepts data_out when valid && ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a good frame is dropped.
REQ-010 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-024) and one bit-period counter of width clog2(CLKS_PER_BIT).
REQ-013 IDLE -> START when rx_s == 0; counter cleared.
REQ-014 START: at count CLKS_PER_BIT/2-1 sample rx_s; if 1 return to IDLE with no output (glitch rejection), else go to DATA with counter cleared.
REQ-015 DATA: sample every CLKS_PER_BIT clocks (mid-bit), shift into byte LSB-first; after 8th sample go to STOP.
REQ-016 STOP: sample after CLKS_PER_BIT clocks; if 1, frame is good; if 0, pulse frame_err next cycle, discard byte, then go to BREAK_WAIT sub-condition of IDLE: no new start accepted until rx_s has been 1 for at least one clock.
REQ-017 Good frame with valid == 0 or (valid && ready) in the same cycle: load data_out, valid = 1 on the next clock edge.
REQ-018 Good frame with valid == 1 and ready == 0: keep old data_out, drop new byte, pulse overrun one cycle.
REQ-019 valid && ready with no frame completing: valid clears next edge; data_out holds its value.
REQ-020 Good frame completes at the end of STOP; the state returns to IDLE in the same edge, so back-to-back frames with a single stop bit are received.

Reset
REQ-021 SHALL on rst_n low, immediately: state IDLE, counter 0, synchronizer 1, data_out 8'h00, valid 0, frame_err 0, overrun 0, busy 0.
REQ-022 Reset mid-frame SHALL abandon the frame with no valid, frame_err or overrun output; reception resumes at the next falling edge after rst_n deasserts.

Configuration
REQ-023 SHALL support macro UART_RX_PARITY_EN; if undefined, frames are 8N1 and no parity logic or port exists.
REQ-024 If defined: state PARITY between DATA and STOP samples one even-parity bit; output port parity_err (1 bit, reset 0) pulses one cycle at end of STOP when parity mismatches; byte is discarded and valid is not raised; frame_err takes priority if both occur.

Structure
REQ-025 SHALL import package uart_pkg holding the state enum, DATA_BITS = 8 and the parity-mode constant, shared with the transmitter.
REQ-026 SHALL instantiate one sub-module uart_rx_sync (2-flop synchronizer, async active-low reset to 1); all other logic resides in uart_receiver.

Verification (CLKS_PER_BIT = 16, clk period 10 ns)
REQ-027 Send 8'h81 as 8N1, ready = 1 -> valid high one cycle, data_out = 8'h81, no error pulses.
REQ-028 rx low for 4 clocks then high -> busy pulses, returns to IDLE, no valid, no frame_err.
REQ-029 Send 8'hAA with stop bit 0 -> frame_err pulse, valid stays 0; next frame 8'h8B is accepted only after rx returns high.
REQ-030 Send 8'h8B then 8'hAA back-to-back with ready = 0 -> data_out = 8'h8B, valid = 1, one overrun pulse; asserting ready clears valid.
REQ-031 Assert rst_n low during DATA bit 4 of 8'hFF -> all outputs at reset values immediately; next frame 8'h01 is received correctly.
REQ-032 With UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 -> parity_err pulse, valid stays 0; with parity bit 1 -> data_out = 8'h07, valid = 1.
